// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - CPU request to APB3 initiator with one-hot PSEL window decode
// Optional ACCESS-phase timeout enabled by defining APB_TIMEOUT_EN.
module apb_master_bridge #(
  parameter int          NUM_SLV     = 4,
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          SPAN_BITS   = 12,
  parameter int          TIMEOUT_CYC = 256
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  input  logic                   transfer,
  input  logic                   write,
  input  logic [31:0]            addr,
  input  logic [31:0]            wdata,
  output logic [31:0]            rdata,
  output logic                   ready,
  output logic                   err,
  output logic                   busy,
  output logic [31:0]            PADDR,
  output logic                   PWRITE,
  output logic [31:0]            PWDATA,
  output logic [NUM_SLV-1:0]     PSEL,
  output logic                   PENABLE,
  input  logic [32*NUM_SLV-1:0]  PRDATA_ALL,
  input  logic [NUM_SLV-1:0]     PREADY_ALL
);

  localparam int IDX_W  = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int PAGE_W = 32 - SPAN_BITS;
  localparam logic [PAGE_W-1:0] NUM_SLV_P = PAGE_W'(NUM_SLV);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t           state;
  logic [IDX_W-1:0] sel_idx;
  logic [PAGE_W-1:0] page_off;
  logic             hit;
  logic             pready_sel;
  logic [31:0]      prdata_sel;

  // Unsigned window offset: addresses below BASE_ADDR wrap to a large value and miss.
  assign page_off   = addr[31:SPAN_BITS] - BASE_ADDR[31:SPAN_BITS];
  assign hit        = (page_off < NUM_SLV_P);
  assign pready_sel = PREADY_ALL[sel_idx];
  assign prdata_sel = PRDATA_ALL[{sel_idx, 5'b00000} +: 32];

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0] acc_cnt;
`endif

  always_ff @(posedge PCLK) begin
    if (!PRESET) begin
      state   <= IDLE;
      sel_idx <= '0;
      PSEL    <= '0;
      PENABLE <= 1'b0;
      PADDR   <= '0;
      PWDATA  <= '0;
      PWRITE  <= 1'b0;
      rdata   <= '0;
      ready   <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
`ifdef APB_TIMEOUT_EN
      acc_cnt <= '0;
`endif
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          if (transfer) begin
            PADDR  <= addr;
            PWDATA <= wdata;
            PWRITE <= write;
            busy   <= 1'b1;
            if (hit) begin
              sel_idx <= page_off[IDX_W-1:0];
              PSEL    <= '0;
              PSEL[page_off[IDX_W-1:0]] <= 1'b1;
              PENABLE <= 1'b0;
              err     <= 1'b0;
              state   <= SETUP;
            end else begin
              err   <= 1'b1;
              state <= DONE;
            end
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
`ifdef APB_TIMEOUT_EN
          acc_cnt <= '0;
`endif
        end
        ACCESS: begin
          if (pready_sel) begin
            if (!PWRITE) rdata <= prdata_sel;
            PSEL    <= '0;
            PENABLE <= 1'b0;
            err     <= 1'b0;
            ready   <= 1'b1;
            state   <= DONE;
          end
`ifdef APB_TIMEOUT_EN
          else if (acc_cnt == CNT_LAST) begin
            PSEL    <= '0;
            PENABLE <= 1'b0;
            err     <= 1'b1;
            ready   <= 1'b1;
            state   <= DONE;
          end else begin
            acc_cnt <= acc_cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          // Decode misses enter DONE with ready low so the pulse lands one cycle later.
          if (!ready) begin
            ready <= 1'b1;
          end else begin
            busy  <= 1'b0;
            err   <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - scoreboard bench for apb_master_bridge
module tb_apb_master_bridge;

  logic         PCLK = 1'b0;
  logic         PRESET = 1'b0;
  logic         transfer = 1'b0;
  logic         write = 1'b0;
  logic [31:0]  addr = '0;
  logic [31:0]  wdata = '0;
  logic [31:0]  rdata;
  logic         ready, err, busy;
  logic [31:0]  PADDR, PWDATA;
  logic         PWRITE, PENABLE;
  logic [3:0]   PSEL;
  logic [127:0] PRDATA_ALL = '0;
  logic [3:0]   PREADY_ALL = '0;

  typedef struct {logic err; logic [31:0] rdata;} exp_t;
  exp_t        sb[$];
  exp_t        e;
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_rdata = '0;

  apb_master_bridge #(
    .NUM_SLV(4), .BASE_ADDR(32'h1000_0000), .SPAN_BITS(12), .TIMEOUT_CYC(4)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET), .transfer(transfer), .write(write),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .err(err),
    .busy(busy), .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA_ALL(PRDATA_ALL), .PREADY_ALL(PREADY_ALL)
  );

  always #5 PCLK = ~PCLK;

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  // Presents a one-cycle request; returns positioned at T+1.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
    transfer = 1'b1; write = w; addr = a; wdata = d;
    step();
    transfer = 1'b0;
  endtask

  task automatic wait_ready(input int budget, output int cyc);
    cyc = 1;
    while (!ready && cyc < budget) begin
      step();
      cyc++;
    end
  endtask

  task automatic test_reset();
    PRESET = 1'b0;
    repeat (3) step();
    vectors++; if ({PSEL, PENABLE, PWRITE, ready, err, busy} !== 9'b0) begin miscompares++; $display("FAIL reset_ctrl: got %b want %b", {PSEL, PENABLE, PWRITE, ready, err, busy}, 9'b0); end
    vectors++; if (PADDR !== 32'h0) begin miscompares++; $display("FAIL reset_paddr: got %h want 0", PADDR); end
    vectors++; if (PWDATA !== 32'h0) begin miscompares++; $display("FAIL reset_pwdata: got %h want 0", PWDATA); end
    vectors++; if (rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    PRESET = 1'b1;
    step();
  endtask

  task automatic test_write_zero_wait();
    PREADY_ALL = 4'b0001;
    sb.push_back('{err: 1'b0, rdata: exp_rdata});
    issue(1'b1, 32'h1000_0000, 32'h0000_0001);
    vectors++; if (PSEL !== 4'b0001) begin miscompares++; $display("FAIL wr_setup_psel: got %b want 0001", PSEL); end
    vectors++; if (PENABLE !== 1'b0) begin miscompares++; $display("FAIL wr_setup_penable: got %b want 0", PENABLE); end
    vectors++; if ({PWRITE, busy} !== 2'b11) begin miscompares++; $display("FAIL wr_setup_pwrite_busy: got %b want 11", {PWRITE, busy}); end
    vectors++; if (PADDR !== 32'h1000_0000 || PWDATA !== 32'h1) begin miscompares++; $display("FAIL wr_setup_bus: got %h/%h want 10000000/00000001", PADDR, PWDATA); end
    step();
    vectors++; if ({PSEL, PENABLE, ready} !== 6'b000110) begin miscompares++; $display("FAIL wr_access: got %b want 000110", {PSEL, PENABLE, ready}); end
    step();
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL wr_ready_t3: got %b want 1", ready); end
    if (sb.size() == 0) begin vectors++; miscompares++; $display("FAIL wr_sb_empty: got 0 entries want 1"); end
    else begin
      e = sb.pop_front();
      vectors++; if (err !== e.err) begin miscompares++; $display("FAIL wr_err: got %b want %b", err, e.err); end
      vectors++; if (rdata !== e.rdata) begin miscompares++; $display("FAIL wr_rdata: got %h want %h", rdata, e.rdata); end
    end
    vectors++; if ({PSEL, PENABLE} !== 5'b0) begin miscompares++; $display("FAIL wr_done_idle_bus: got %b want 00000", {PSEL, PENABLE}); end
    step();
    vectors++; if ({ready, busy} !== 2'b00) begin miscompares++; $display("FAIL wr_after: got %b want 00", {ready, busy}); end
  endtask

  task automatic test_read_wait_states();
    PREADY_ALL = 4'b0010;
    PRDATA_ALL = {32'hDEAD_0003, 32'h0000_0123, 32'hDEAD_0001, 32'hDEAD_0000};
    sb.push_back('{err: 1'b0, rdata: 32'h0000_0123});
    exp_rdata = 32'h0000_0123;
    issue(1'b0, 32'h1000_2008, 32'hFFFF_FFFF);
    for (int k = 1; k <= 4; k++) begin
      vectors++; if (PSEL !== 4'b0100 || PADDR !== 32'h1000_2008) begin miscompares++; $display("FAIL rd_hold_k%0d: got %b/%h want 0100/10002008", k, PSEL, PADDR); end
      vectors++; if (PENABLE !== (k >= 2) || ready !== 1'b0) begin miscompares++; $display("FAIL rd_phase_k%0d: got en=%b rdy=%b want en=%b rdy=0", k, PENABLE, ready, (k >= 2)); end
      if (k == 4) PREADY_ALL = 4'b0110;
      step();
    end
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL rd_ready_t5: got %b want 1", ready); end
    if (sb.size() == 0) begin vectors++; miscompares++; $display("FAIL rd_sb_empty: got 0 entries want 1"); end
    else begin
      e = sb.pop_front();
      vectors++; if (err !== e.err) begin miscompares++; $display("FAIL rd_err: got %b want %b", err, e.err); end
      vectors++; if (rdata !== e.rdata) begin miscompares++; $display("FAIL rd_rdata: got %h want %h", rdata, e.rdata); end
    end
    PREADY_ALL = 4'b0010;
    step();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rd_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_decode_miss();
    logic [31:0] miss_addr [2];
    miss_addr[0] = 32'h2000_0000;
    miss_addr[1] = 32'h0FFF_FFFC;
    PREADY_ALL = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{err: 1'b1, rdata: exp_rdata});
      issue(1'b0, miss_addr[i], 32'h0);
      vectors++; if ({PSEL, PENABLE, busy, ready} !== 7'b0000010) begin miscompares++; $display("FAIL miss%0d_t1: got %b want 0000010", i, {PSEL, PENABLE, busy, ready}); end
      step();
      vectors++; if ({ready, PSEL, PENABLE} !== 6'b100000) begin miscompares++; $display("FAIL miss%0d_t2: got %b want 100000", i, {ready, PSEL, PENABLE}); end
      if (sb.size() == 0) begin vectors++; miscompares++; $display("FAIL miss%0d_sb_empty: got 0 entries want 1", i); end
      else begin
        e = sb.pop_front();
        vectors++; if (err !== e.err) begin miscompares++; $display("FAIL miss%0d_err: got %b want %b", i, err, e.err); end
        vectors++; if (rdata !== e.rdata) begin miscompares++; $display("FAIL miss%0d_rdata: got %h want %h", i, rdata, e.rdata); end
      end
      step();
      vectors++; if ({ready, busy} !== 2'b00) begin miscompares++; $display("FAIL miss%0d_after: got %b want 00", i, {ready, busy}); end
    end
  endtask

  task automatic test_busy_drop();
    int rdy_cnt, sel_cnt;
    PREADY_ALL = 4'b0000;
    sb.push_back('{err: 1'b0, rdata: exp_rdata});
    issue(1'b1, 32'h1000_3000, 32'hAAAA_5555);
    step();
    transfer = 1'b1; write = 1'b0; addr = 32'h1000_0000;
    step();
    transfer = 1'b0;
    vectors++; if ({PSEL, PENABLE, PWRITE} !== 6'b100011 || PADDR !== 32'h1000_3000) begin miscompares++; $display("FAIL busy_access: got %b/%h want 100011/10003000", {PSEL, PENABLE, PWRITE}, PADDR); end
    PREADY_ALL = 4'b1000;
    step();
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL busy_ready: got %b want 1", ready); end
    if (sb.size() == 0) begin vectors++; miscompares++; $display("FAIL busy_sb_empty: got 0 entries want 1"); end
    else begin
      e = sb.pop_front();
      vectors++; if (err !== e.err || rdata !== e.rdata) begin miscompares++; $display("FAIL busy_result: got %b/%h want %b/%h", err, rdata, e.err, e.rdata); end
    end
    PREADY_ALL = 4'b1111;
    transfer = 1'b1;
    step();
    transfer = 1'b0;
    rdy_cnt = 0; sel_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (ready) rdy_cnt++;
      if (PSEL != 4'b0) sel_cnt++;
      step();
    end
    vectors++; if (rdy_cnt !== 0) begin miscompares++; $display("FAIL busy_extra_ready: got %0d want 0", rdy_cnt); end
    vectors++; if (sel_cnt !== 0) begin miscompares++; $display("FAIL busy_extra_psel: got %0d want 0", sel_cnt); end
  endtask

`ifdef APB_TIMEOUT_EN
  task automatic test_timeout();
    int cyc;
    PREADY_ALL = 4'b0000;
    PRDATA_ALL[63:32] = 32'h0000_5A5A;
    sb.push_back('{err: 1'b1, rdata: exp_rdata});
    issue(1'b0, 32'h1000_1004, 32'h0);
    wait_ready(20, cyc);
    vectors++; if (cyc !== 6) begin miscompares++; $display("FAIL to_latency: got %0d want 6", cyc); end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      vectors++; if (err !== e.err || rdata !== e.rdata || PSEL !== 4'b0) begin miscompares++; $display("FAIL to_result: got %b/%h/%b want %b/%h/0000", err, rdata, PSEL, e.err, e.rdata); end
    end
    step();
    sb.push_back('{err: 1'b0, rdata: 32'h0000_5A5A});
    exp_rdata = 32'h0000_5A5A;
    issue(1'b0, 32'h1000_1004, 32'h0);
    repeat (4) step();
    PREADY_ALL = 4'b0010;
    step();
    PREADY_ALL = 4'b0000;
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL to_edge_ready: got %b want 1", ready); end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      vectors++; if (err !== e.err || rdata !== e.rdata) begin miscompares++; $display("FAIL to_edge_result: got %b/%h want %b/%h", err, rdata, e.err, e.rdata); end
    end
    step();
  endtask
`endif

  task automatic test_reset_mid_access();
    int cyc, rdy_cnt;
    PREADY_ALL = 4'b0000;
    issue(1'b0, 32'h1000_1000, 32'h0);
    step();
    vectors++; if ({PSEL, PENABLE} !== 5'b00101) begin miscompares++; $display("FAIL rst_pre_access: got %b want 00101", {PSEL, PENABLE}); end
    PRESET = 1'b0;
    step();
    PRESET = 1'b1;
    exp_rdata = 32'h0;
    vectors++; if ({PSEL, PENABLE, busy, ready} !== 8'b0) begin miscompares++; $display("FAIL rst_abort: got %b want 00000000", {PSEL, PENABLE, busy, ready}); end
    vectors++; if (rdata !== exp_rdata) begin miscompares++; $display("FAIL rst_rdata: got %h want %h", rdata, exp_rdata); end
    PREADY_ALL = 4'b1111;
    rdy_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      if (ready) rdy_cnt++;
      step();
    end
    vectors++; if (rdy_cnt !== 0) begin miscompares++; $display("FAIL rst_no_ready: got %0d want 0", rdy_cnt); end
    PRDATA_ALL[31:0] = 32'hCAFE_F00D;
    sb.push_back('{err: 1'b0, rdata: 32'hCAFE_F00D});
    exp_rdata = 32'hCAFE_F00D;
    issue(1'b0, 32'h1000_0010, 32'h0);
    wait_ready(20, cyc);
    vectors++; if (cyc !== 3) begin miscompares++; $display("FAIL rst_next_latency: got %0d want 3", cyc); end
    if (sb.size() == 0) begin vectors++; miscompares++; $display("FAIL rst_sb_empty: got 0 entries want 1"); end
    else begin
      e = sb.pop_front();
      vectors++; if (err !== e.err || rdata !== e.rdata) begin miscompares++; $display("FAIL rst_next_result: got %b/%h want %b/%h", err, rdata, e.err, e.rdata); end
    end
    step();
    vectors++; if (sb.size() !== 0) begin miscompares++; $display("FAIL sb_leftover: got %0d want 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_wait_states();
    test_decode_miss();
    test_busy_drop();
`ifdef APB_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_access();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
APB initiator (requester side of the peripheral bus) that converts single-cycle CPU data-bus requests into APB3 transfers, and decodes the address into one-hot PSEL across NUM_SLV slave windows (ultrasound, GPIO, UART, ...). It waits on the selected slave's PREADY and returns read data and status to the CPU. It is the master counterpart of the existing APB slave peripherals.

Parameters:
NUM_SLV, 4, number of slave windows / PSEL lines
BASE_ADDR, 32'h1000_0000, start address of slave 0 window
SPAN_BITS, 12, log2 window size; slave i occupies BASE_ADDR + i*2^SPAN_BITS
TIMEOUT_CYC, 256, ACCESS-phase cycle limit (used only with APB_TIMEOUT_EN)

Ports:
PCLK  in  1  clock
PRESET  in  1  reset, synchronous, active-low
transfer  in  1  one-cycle request strobe from CPU
write  in  1  1=write, 0=read; sampled with transfer
addr  in  32  byte address; sampled with transfer
wdata  in  32  write data; sampled with transfer
rdata  out  32  read data, valid when ready=1 and err=0 on a read
ready  out  1  one-cycle completion pulse
err  out  1  error status, valid with ready
busy  out  1  transfer in progress; transfer is ignored while busy=1
PADDR  out  32  APB address
PWRITE  out  1  APB direction
PWDATA  out  32  APB write data
PSEL  out  NUM_SLV  one-hot slave select
PENABLE  out  1  APB access phase
PRDATA_ALL  in  32*NUM_SLV  slave read data; slave i on bits [32i+31:32i]
PREADY_ALL  in  NUM_SLV  slave ready; bit i from slave i

Behaviour:
- One clock: PCLK. Reset is synchronous and active-low: PRESET=0 sampled on a PCLK rising edge resets the block.
- Reset values: state=IDLE, PSEL=0, PENABLE=0, PADDR=0, PWDATA=0, PWRITE=0, rdata=0, ready=0, err=0, busy=0.
- Reset mid-transfer aborts immediately: PSEL and PENABLE drop at that edge, and no ready pulse is issued.
- All outputs are registered.
- Decode: hit when addr[31:SPAN_BITS] - BASE_ADDR[31:SPAN_BITS] < NUM_SLV; slave index = that difference. The subtraction is unsigned, so an address below BASE_ADDR wraps and misses.
- FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE, transfer=1:
  - Latch addr/wdata/write into PADDR/PWDATA/PWRITE and set busy=1.
  - On a hit, go to SETUP with PSEL[idx]=1 and PENABLE=0.
  - On a miss, go to DONE with err=1, rdata unchanged, and no APB activity.
- SETUP: exactly one cycle, then ACCESS with PENABLE=1. PREADY is ignored in SETUP.
- ACCESS: hold PADDR/PWDATA/PWRITE/PSEL stable. Sample PREADY_ALL[idx] each cycle; PREADY from unselected slaves is ignored. When it is 1:
  - Read: capture the PRDATA_ALL slice into rdata.
  - Then PSEL=0, PENABLE=0, go to DONE with err=0.
- DONE: ready=1 for exactly one cycle, then IDLE with busy=0.
- Write transfers leave rdata unchanged.
- Minimum latency, zero wait states: transfer at cycle T gives SETUP at T+1, ACCESS at T+2 with PREADY=1, ready at T+3. Each wait state adds one cycle.
- transfer asserted while busy=1, including during DONE, is dropped and not queued.
- busy=1 from T+1 through the ready cycle.
- PENABLE=1 only while some PSEL bit is 1. PSEL is never multi-hot.

Optional Feature:
APB_TIMEOUT_EN
- Defined: ACCESS counts cycles from 0. If PREADY_ALL[idx] is still 0 after TIMEOUT_CYC ACCESS cycles, the block drops PSEL/PENABLE, goes to DONE with err=1, and leaves rdata unchanged.
- PREADY arriving in the same cycle the count reaches TIMEOUT_CYC-1 completes normally; PREADY wins.
- Undefined: ACCESS waits indefinitely, the counter logic is absent, and err is set only by decode misses.

Test Plan:
1. Write, zero wait states: transfer with write=1, addr=0x1000_0000, wdata=0x0000_0001, PREADY_ALL[0]=1 in ACCESS -> PSEL=4'b0001, PENABLE high for 1 cycle, PWDATA=0x1; ready=1, err=0 at T+3; rdata unchanged.
2. Read, two wait states, slave 2: transfer with read, addr=0x1000_2008, PRDATA_ALL[95:64]=0x0000_0123, PREADY_ALL[2] high on the 3rd ACCESS cycle -> PSEL=4'b0100 and PADDR held the whole time; rdata=0x123, err=0 at T+5. PREADY_ALL[1]=1 throughout has no effect.
3. Decode miss: read at addr=0x2000_0000, and separately at 0x0FFF_FFFC -> PSEL stays 0, PENABLE stays 0; ready=1, err=1 at T+2; rdata keeps its prior value.
4. Busy drop: second transfer pulsed during ACCESS, and another during DONE -> only the first transfer appears on APB; exactly one ready pulse.
5. Timeout (APB_TIMEOUT_EN, TIMEOUT_CYC=4): read slave 1 with PREADY low -> after 4 ACCESS cycles PSEL=0, ready=1, err=1. Variant with PREADY on the 4th ACCESS cycle -> err=0 and rdata captured.
6. Reset mid-ACCESS: PRESET=0 for one edge during ACCESS -> at that edge PSEL=0, PENABLE=0, busy=0; no ready pulse; the next transfer after reset completes normally.
